// File: rtl/mdu_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// Both sides use valid/ready: a transfer happens on the rising edge where valid && ready.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, hi, lo, dz
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, hi, lo, dz
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply, divide and remainder, one bit per clock.
// The datapath works on magnitudes; signs are applied once in FIX.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_iter_if.slave  bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mag_b;
    logic               bz_q;
    logic               neg_p;
    logic               neg_r;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;

    logic               accept;
    logic               signed_in;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign accept       = (state == IDLE) && bus.in_valid;
    assign bus.in_ready = (state == IDLE);
    assign state_dbg    = state;

    // op 0 (MULT) and op 2 (DIV) are the signed ones
    assign signed_in = ~bus.op[0];
    assign abs_a     = (signed_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b     = (signed_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid) state_nx = RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted[WIDTH-1:0] - mag_b;
        acc_nx  = {sum, acc[WIDTH-1:1]};
        if (op_q[1]) begin
            if (shifted >= {1'b0, mag_b}) begin
                acc_nx = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod = neg_p ? -acc : acc;
        quo  = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            op_q          <= '0;
            a_q           <= '0;
            mag_b         <= '0;
            bz_q          <= 1'b0;
            neg_p         <= 1'b0;
            neg_r         <= 1'b0;
            acc           <= '0;
            bus.hi        <= '0;
            bus.lo        <= '0;
            bus.dz        <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (accept) begin
                cnt   <= '0;
                op_q  <= bus.op;
                a_q   <= bus.a;
                mag_b <= abs_b;
                bz_q  <= (bus.b == '0);
                neg_p <= signed_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r <= signed_in & bus.a[WIDTH-1];
                acc   <= {{WIDTH{1'b0}}, abs_a};
            end
            if (state == RUN) begin
                acc <= acc_nx;
                cnt <= cnt + CW'(1);
            end
            if (state == FIX) begin
                bus.out_valid <= 1'b1;
                if (!op_q[1]) begin
                    {bus.hi, bus.lo} <= prod;
                    bus.dz           <= 1'b0;
                end else if (bz_q) begin
                    bus.hi <= a_q;
                    bus.lo <= '1;
                    bus.dz <= 1'b1;
                end else begin
                    bus.hi <= rem;
                    bus.lo <= quo;
                    bus.dz <= 1'b0;
                end
            end
            if (state == DONE && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomised bench for mdu_iter at WIDTH=32 and WIDTH=8.
module tb_mdu_iter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state32;
    logic [1:0] state8;
    int         errors = 0;
    int         checks = 0;

    // expected {dz, hi, lo}; 8-bit results sit in the low byte of each field
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(32)) bus32 ();
    mdu_iter_if #(.WIDTH(8))  bus8 ();

    mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32), .state_dbg(state32));
    mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8),  .state_dbg(state8));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural reference: plain integer arithmetic at any width up to 32
    function automatic logic [64:0] ref_model(input int w, input logic [1:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        longint unsigned hi;
        longint unsigned lo;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        logic            dz;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        sa = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        dz = 1'b0;
        hi = 0;
        lo = 0;
        if (op == 2'd0 || op == 2'd1) begin
            if (op == 2'd0) p = longint'(sa * sb);
            else            p = ua * ub;
            lo = p & mask;
            hi = (p >> w) & mask;
        end else if (ub == 0) begin
            dz = 1'b1;
            lo = mask;
            hi = ua;
        end else if (op == 2'd2) begin
            q  = sa / sb;
            r  = sa % sb;
            lo = longint'(q) & mask;
            hi = longint'(r) & mask;
        end else begin
            lo = ua / ub;
            hi = ua % ub;
        end
        return {dz, hi[31:0], lo[31:0]};
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return mask;
            3:       return 32'd1 << (w - 1);
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [64:0] res, output int lat, output bit ir_low);
        int w;
        res = '0;
        lat = 0;
        ir_low = 1'b1;
        @(negedge clk);
        bus32.op = op;
        bus32.a = a;
        bus32.b = b;
        bus32.in_valid = 1'b1;
        w = 0;
        while (!bus32.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus32.in_ready) begin
            checks++;
            errors++;
            $display("FAIL run32_accept: in_ready=%b required 1", bus32.in_ready);
            bus32.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        bus32.op = 2'($urandom);
        bus32.a = $urandom;
        bus32.b = $urandom;
        while (!bus32.out_valid && lat < 200) begin
            if (bus32.in_ready) ir_low = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus32.out_valid) begin
            checks++;
            errors++;
            $display("FAIL run32_done: out_valid=0 after %0d cycles, required 1", lat);
            return;
        end
        if (bus32.in_ready) ir_low = 1'b0;
        res = {bus32.dz, bus32.hi, bus32.lo};
        bus32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [64:0] res, output int lat);
        int w;
        res = '0;
        lat = 0;
        @(negedge clk);
        bus8.op = op;
        bus8.a = a;
        bus8.b = b;
        bus8.in_valid = 1'b1;
        w = 0;
        while (!bus8.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus8.in_ready) begin
            checks++;
            errors++;
            $display("FAIL run8_accept: in_ready=%b required 1", bus8.in_ready);
            bus8.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        while (!bus8.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus8.out_valid) begin
            checks++;
            errors++;
            $display("FAIL run8_done: out_valid=0 after %0d cycles, required 1", lat);
            return;
        end
        res = {bus8.dz, 24'd0, bus8.hi, 24'd0, bus8.lo};
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus32.in_ready, bus32.out_valid, bus32.dz} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags32: in_ready/out_valid/dz=%b required 100",
                     {bus32.in_ready, bus32.out_valid, bus32.dz});
        end
        checks++;
        if ({bus32.hi, bus32.lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_result32: hi,lo=%h required 0", {bus32.hi, bus32.lo});
        end
        checks++;
        if ({bus8.in_ready, bus8.out_valid, bus8.dz, bus8.hi, bus8.lo} !== {3'b100, 16'd0}) begin
            errors++;
            $display("FAIL reset_w8: got %h required %h",
                     {bus8.in_ready, bus8.out_valid, bus8.dz, bus8.hi, bus8.lo}, {3'b100, 16'd0});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [64:0] exp);
        logic [64:0] res;
        int          lat;
        bit          ir_low;
        run32(op, a, b, res, lat, ir_low);
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL %s: {dz,hi,lo}=%h required %h", name, res, exp);
        end
        checks++;
        if (lat != 33 || !ir_low) begin
            errors++;
            $display("FAIL %s_timing: latency=%0d in_ready_low=%0b required 33/1", name, lat, ir_low);
        end
    endtask

    task automatic test_mult();
        check_op("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
        check_op("multu_ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        check_op("mult_ones", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h1});
    endtask

    task automatic test_div();
        check_op("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check_op("divu_7_2", 2'd3, 32'd7, 32'd2, {1'b0, 32'd1, 32'd3});
        check_op("div_7_neg2", 2'd2, 32'd7, 32'hFFFF_FFFE, {1'b0, 32'd1, 32'hFFFF_FFFD});
    endtask

    task automatic test_div_corners();
        check_op("divu_by_zero", 2'd3, 32'd7, 32'd0, {1'b1, 32'd7, 32'hFFFF_FFFF});
        check_op("div_by_zero", 2'd2, 32'hFFFF_FFFB, 32'd0, {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
        check_op("div_overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0, 32'h8000_0000});
    endtask

    task automatic test_backpressure();
        int w;
        @(negedge clk);
        bus32.op = 2'd1;
        bus32.a = 32'h0000_1234;
        bus32.b = 32'h0000_0010;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        w = 0;
        while (!bus32.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!bus32.out_valid || {bus32.hi, bus32.lo} !== 64'h0000_0000_0001_2340) begin
            errors++;
            $display("FAIL bp_result: valid=%b hi,lo=%h required 1/0000000000012340",
                     bus32.out_valid, {bus32.hi, bus32.lo});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus32.out_valid, bus32.in_ready, bus32.hi, bus32.lo} !== {2'b10, 64'h0000_0000_0001_2340}) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid/ready=%b%b hi,lo=%h required 10/0000000000012340",
                         i, bus32.out_valid, bus32.in_ready, {bus32.hi, bus32.lo});
            end
        end
        bus32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.out_ready = 1'b0;
        checks++;
        if ({bus32.in_ready, bus32.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: in_ready/out_valid=%b required 10", {bus32.in_ready, bus32.out_valid});
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus32.op = 2'd0;
        bus32.a = 32'h1234_5678;
        bus32.b = 32'h09AB_CDEF;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus32.out_valid, bus32.dz, bus32.hi, bus32.lo, bus32.in_ready} !== {2'b00, 64'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: valid/dz=%b%b hi,lo=%h in_ready=%b required 00/0/1",
                     bus32.out_valid, bus32.dz, {bus32.hi, bus32.lo}, bus32.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_op("after_reset_6x7", 2'd0, 32'd6, 32'd7, {1'b0, 32'd0, 32'd42});
    endtask

    task automatic test_back_to_back();
        int seen;
        int c;
        bit prev_ov;
        seen = 0;
        c = 0;
        prev_ov = 1'b0;
        @(negedge clk);
        bus32.op = 2'd2;
        bus32.a = 32'hFFFF_FF9C;
        bus32.b = 32'd7;
        bus32.in_valid = 1'b1;
        bus32.out_ready = 1'b1;
        while (seen < 3 && c < 300) begin
            @(negedge clk);
            c++;
            if (prev_ov) begin
                checks++;
                if ({bus32.in_ready, bus32.out_valid} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_single_valid: in_ready/out_valid=%b required 10",
                             {bus32.in_ready, bus32.out_valid});
                end
            end
            if (bus32.out_valid) begin
                seen++;
                checks++;
                if ({bus32.dz, bus32.hi, bus32.lo} !== {1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
                    errors++;
                    $display("FAIL b2b_result: {dz,hi,lo}=%h required 0fffffffefffffff2",
                             {bus32.dz, bus32.hi, bus32.lo});
                end
                if (seen == 3) bus32.in_valid = 1'b0;
            end
            prev_ov = bus32.out_valid;
        end
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL b2b_count: results=%0d required 3", seen);
        end
        @(negedge clk);
        bus32.out_ready = 1'b0;
        checks++;
        if ({bus32.in_ready, bus32.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_idle: in_ready/out_valid=%b required 10", {bus32.in_ready, bus32.out_valid});
        end
    endtask

    task automatic test_random32();
        logic [64:0] res;
        logic [64:0] exp;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          lat;
        bit          ir_low;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = pick(32);
            b = pick(32);
            exp_q.push_back(ref_model(32, op, a, b));
            run32(op, a, b, res, lat, ir_low);
            exp = exp_q.pop_front();
            checks++;
            if (res !== exp || lat != 33) begin
                errors++;
                $display("FAIL rand32: op=%0d a=%h b=%h got %h lat=%0d required %h lat=33",
                         op, a, b, res, lat, exp);
            end
        end
    endtask

    task automatic test_random8();
        logic [64:0] res;
        logic [64:0] exp;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a = pick(8);
            b = pick(8);
            exp_q.push_back(ref_model(8, op, a, b));
            run8(op, a[7:0], b[7:0], res, lat);
            exp = exp_q.pop_front();
            checks++;
            if (res !== exp || lat != 9) begin
                errors++;
                $display("FAIL rand8: op=%0d a=%h b=%h got %h lat=%0d required %h lat=9",
                         op, a[7:0], b[7:0], res, lat, exp);
            end
        end
    endtask

    initial begin
        bus32.in_valid = 1'b0;
        bus32.op = 2'd0;
        bus32.a = '0;
        bus32.b = '0;
        bus32.out_ready = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.op = 2'd0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.out_ready = 1'b0;

        test_reset();
        test_mult();
        test_div();
        test_div_corners();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random32();
        test_random8();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
